// File: rtl/usb_ls_pkg.sv
// +-------------------------------------------------------------------------+
// | usb_ls_pkg: PIDs, request codes, FSM encodings for the LS HID device     |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
`default_nettype none

package usb_ls_pkg;

  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
  localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'h06;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;
  localparam logic [7:0] DESC_TYPE_DEVICE      = 8'h01;

  localparam logic [4:0] DEV_DESC_BYTES = 5'd18;

  // 18-byte keyboard device descriptor, byte0 in [7:0]
  localparam logic [143:0] DEV_DESC_DEFAULT =
    144'h01_00_02_01_01_00_56_78_12_34_08_00_00_00_01_10_01_12;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_SETUP_DATA = 2'd1;
  localparam logic [1:0] S_OUT_DATA   = 2'd2;
  localparam logic [1:0] S_WAIT_ACK   = 2'd3;

  typedef enum logic [1:0] {
    CS_IDLE      = 2'd0,
    CS_DATA_IN   = 2'd1,
    CS_STATUS_IN = 2'd2,
    CS_STALL     = 2'd3
  } ctrl_stage_e;

  function automatic logic [7:0] data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_ls_hid_device_responder_if.sv
// +-------------------------------------------------------------------------+
// | usb_ls_hid_device_responder_if: PHY packet and HID report handshakes    |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
`default_nettype none

interface usb_ls_hid_device_responder_if;
  logic        bus_reset;
  logic        rx_flip_in;
  logic [7:0]  rx_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic [3:0]  rx_len;
  logic [63:0] rx_data;
  logic        rx_crc_ok;
  logic        tx_flip_out;
  logic [7:0]  tx_pid;
  logic [63:0] tx_data;
  logic [3:0]  tx_len;
  logic [63:0] report;
  logic        report_flip_in;
  logic        report_ack_flip_out;
  logic [6:0]  dev_addr;
  logic        configured;

  modport master (
    output bus_reset, rx_flip_in, rx_pid, rx_addr, rx_endp, rx_len, rx_data,
           rx_crc_ok, report, report_flip_in,
    input  tx_flip_out, tx_pid, tx_data, tx_len, report_ack_flip_out,
           dev_addr, configured
  );

  modport slave (
    input  bus_reset, rx_flip_in, rx_pid, rx_addr, rx_endp, rx_len, rx_data,
           rx_crc_ok, report, report_flip_in,
    output tx_flip_out, tx_pid, tx_data, tx_len, report_ack_flip_out,
           dev_addr, configured
  );
endinterface

`default_nettype wire

// File: rtl/usb_ls_desc_rom.sv
// +-------------------------------------------------------------------------+
// | usb_ls_desc_rom: 8-byte window of the device descriptor at a byte offset |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
`default_nettype none

module usb_ls_desc_rom
  import usb_ls_pkg::*;
#(
  parameter logic [143:0] DEV_DESC = DEV_DESC_DEFAULT
) (
  input  logic [4:0]  offset_i,
  output logic [63:0] window_o
);

  // Eight zero bytes past the end keep the window zero-padded at any offset
  logic [207:0] w_padded;

  assign w_padded = {64'd0, DEV_DESC};

  always_comb begin
    window_o = 64'(w_padded >> {offset_i, 3'b000});
  end

endmodule

`default_nettype wire

// File: rtl/usb_ls_hid_device_responder.sv
// +-------------------------------------------------------------------------+
// | usb_ls_hid_device_responder: EP0 control + EP1 interrupt-IN HID device  |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
`default_nettype none

module usb_ls_hid_device_responder
  import usb_ls_pkg::*;
#(
  parameter logic [143:0] DEV_DESC    = DEV_DESC_DEFAULT,
  parameter int           ACK_TIMEOUT = 1024
) (
  input logic                          clk,
  input logic                          reset,
  usb_ls_hid_device_responder_if.slave bus
);

  localparam int             CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic             rx_flip_q, rx_flip_d;
  logic [1:0]       state_q, state_d;
  ctrl_stage_e      stage_q, stage_d;
  logic [6:0]       dev_addr_q, dev_addr_d;
  logic [6:0]       pend_addr_q, pend_addr_d;
  logic             pend_cfg_q, pend_cfg_d;
  logic             req_addr_q, req_addr_d;
  logic             req_cfg_q, req_cfg_d;
  logic             configured_q, configured_d;
  logic             ep0_tog_q, ep0_tog_d;
  logic             ep1_tog_q, ep1_tog_d;
  logic [4:0]       desc_len_q, desc_len_d;
  logic [4:0]       offset_q, offset_d;
  logic             wait_ep1_q, wait_ep1_d;
  logic [3:0]       wait_len_q, wait_len_d;
  logic             rpt_snap_q, rpt_snap_d;
  logic             rpt_ack_q, rpt_ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_flip_q, tx_flip_d;
  logic [7:0]       tx_pid_q, tx_pid_d;
  logic [63:0]      tx_data_q, tx_data_d;
  logic [3:0]       tx_len_q, tx_len_d;

  logic        w_is_token, w_accept, w_ep0, w_rpt_pending;
  logic [63:0] w_window, w_chunk_data;
  logic [4:0]  w_rem;
  logic [3:0]  w_chunk;
  logic [7:0]  w_breq;
  logic [15:0] w_wvalue, w_wlength;
  logic        w_send;
  logic [7:0]  w_reply_pid;
  logic [63:0] w_reply_data;
  logic [3:0]  w_reply_len;

  usb_ls_desc_rom #(.DEV_DESC(DEV_DESC)) u_desc_rom (
    .offset_i (offset_q),
    .window_o (w_window)
  );

  assign w_is_token = (bus.rx_pid == PID_SETUP) || (bus.rx_pid == PID_IN) ||
                      (bus.rx_pid == PID_OUT);
  assign w_accept   = (bus.rx_flip_in != rx_flip_q) && bus.rx_crc_ok &&
                      (!w_is_token || (bus.rx_addr == dev_addr_q));
  assign w_ep0      = (bus.rx_endp == 4'd0);
  // The ack toggle doubles as the consumed-report copy of report_flip_in
  assign w_rpt_pending = (bus.report_flip_in != rpt_ack_q);

  assign w_breq    = bus.rx_data[15:8];
  assign w_wvalue  = bus.rx_data[31:16];
  assign w_wlength = bus.rx_data[63:48];

  assign w_rem   = desc_len_q - offset_q;
  assign w_chunk = (w_rem > 5'd8) ? 4'd8 : w_rem[3:0];

  always_comb begin
    w_chunk_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < w_chunk) w_chunk_data[i*8 +: 8] = w_window[i*8 +: 8];
    end
  end

  always_comb begin
    rx_flip_d    = bus.rx_flip_in;
    state_d      = state_q;
    stage_d      = stage_q;
    dev_addr_d   = dev_addr_q;
    pend_addr_d  = pend_addr_q;
    pend_cfg_d   = pend_cfg_q;
    req_addr_d   = req_addr_q;
    req_cfg_d    = req_cfg_q;
    configured_d = configured_q;
    ep0_tog_d    = ep0_tog_q;
    ep1_tog_d    = ep1_tog_q;
    desc_len_d   = desc_len_q;
    offset_d     = offset_q;
    wait_ep1_d   = wait_ep1_q;
    wait_len_d   = wait_len_q;
    rpt_snap_d   = rpt_snap_q;
    rpt_ack_d    = rpt_ack_q;
    cnt_d        = cnt_q;
    w_send       = 1'b0;
    w_reply_pid  = PID_NAK;
    w_reply_data = '0;
    w_reply_len  = '0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if ((bus.rx_pid == PID_SETUP) && w_ep0) begin
            state_d = S_SETUP_DATA;
          end else if ((bus.rx_pid == PID_OUT) && w_ep0) begin
            state_d = S_OUT_DATA;
          end else if (bus.rx_pid == PID_IN) begin
            w_send = 1'b1;
            if (w_ep0) begin
              case (stage_q)
                CS_DATA_IN: begin
                  w_reply_pid  = data_pid(ep0_tog_q);
                  w_reply_data = w_chunk_data;
                  w_reply_len  = w_chunk;
                  state_d      = S_WAIT_ACK;
                  wait_ep1_d   = 1'b0;
                  wait_len_d   = w_chunk;
                  cnt_d        = '0;
                end
                CS_STATUS_IN: begin
                  w_reply_pid = PID_DATA1;
                  state_d     = S_WAIT_ACK;
                  wait_ep1_d  = 1'b0;
                  wait_len_d  = 4'd0;
                  cnt_d       = '0;
                end
                CS_STALL: w_reply_pid = PID_STALL;
                default:  w_reply_pid = PID_NAK;
              endcase
            end else if (bus.rx_endp == 4'd1) begin
              if (!configured_q) begin
                w_reply_pid = PID_STALL;
              end else if (!w_rpt_pending) begin
                w_reply_pid = PID_NAK;
              end else begin
                w_reply_pid  = data_pid(ep1_tog_q);
                w_reply_data = bus.report;
                w_reply_len  = 4'd8;
                state_d      = S_WAIT_ACK;
                wait_ep1_d   = 1'b1;
                rpt_snap_d   = bus.report_flip_in;
                cnt_d        = '0;
              end
            end else begin
              w_reply_pid = PID_STALL;
            end
          end
        end
      end

      S_SETUP_DATA: begin
        if (w_accept) begin
          state_d = S_IDLE;
          if ((bus.rx_pid == PID_DATA0) && (bus.rx_len == 4'd8)) begin
            w_send      = 1'b1;
            w_reply_pid = PID_ACK;
            ep0_tog_d   = 1'b1;
            req_addr_d  = 1'b0;
            req_cfg_d   = 1'b0;
            stage_d     = CS_STALL;
            if (w_breq == REQ_SET_ADDRESS) begin
              pend_addr_d = w_wvalue[6:0];
              req_addr_d  = 1'b1;
              stage_d     = CS_STATUS_IN;
            end else if (w_breq == REQ_SET_CONFIGURATION) begin
              pend_cfg_d = (w_wvalue[7:0] != 8'd0);
              req_cfg_d  = 1'b1;
              stage_d    = CS_STATUS_IN;
            end else if ((w_breq == REQ_GET_DESCRIPTOR) &&
                         (w_wvalue[15:8] == DESC_TYPE_DEVICE)) begin
              desc_len_d = (w_wlength > 16'(DEV_DESC_BYTES)) ? DEV_DESC_BYTES
                                                             : w_wlength[4:0];
              offset_d   = 5'd0;
              stage_d    = CS_DATA_IN;
            end
          end
        end
      end

      S_OUT_DATA: begin
        if (w_accept) begin
          state_d = S_IDLE;
          if ((bus.rx_pid == PID_DATA0) || (bus.rx_pid == PID_DATA1)) begin
            w_send      = 1'b1;
            w_reply_pid = PID_ACK;
          end
        end
      end

      default: begin
        cnt_d = cnt_q + 1'b1;
        if (w_accept) begin
          state_d = S_IDLE;
          if (bus.rx_pid == PID_ACK) begin
            if (wait_ep1_q) begin
              ep1_tog_d = ~ep1_tog_q;
              rpt_ack_d = rpt_snap_q;
            end else if (stage_q == CS_DATA_IN) begin
              offset_d  = offset_q + {1'b0, wait_len_q};
              ep0_tog_d = ~ep0_tog_q;
            end else if (stage_q == CS_STATUS_IN) begin
              if (req_addr_q) dev_addr_d = pend_addr_q;
              if (req_cfg_q) configured_d = pend_cfg_q;
              stage_d = CS_IDLE;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end
      end
    endcase

    tx_flip_d = tx_flip_q;
    tx_pid_d  = tx_pid_q;
    tx_data_d = tx_data_q;
    tx_len_d  = tx_len_q;
    if (w_send) begin
      tx_flip_d = ~tx_flip_q;
      tx_pid_d  = w_reply_pid;
      tx_data_d = w_reply_data;
      tx_len_d  = w_reply_len;
    end
  end

  // rx copy follows the PHY during reset so an in-flight packet is dropped
  always_ff @(posedge clk) begin
    if (reset || bus.bus_reset) begin
      rx_flip_q    <= bus.rx_flip_in;
      state_q      <= S_IDLE;
      stage_q      <= CS_IDLE;
      dev_addr_q   <= '0;
      pend_addr_q  <= '0;
      pend_cfg_q   <= 1'b0;
      req_addr_q   <= 1'b0;
      req_cfg_q    <= 1'b0;
      configured_q <= 1'b0;
      ep0_tog_q    <= 1'b0;
      ep1_tog_q    <= 1'b0;
      desc_len_q   <= '0;
      offset_q     <= '0;
      wait_ep1_q   <= 1'b0;
      wait_len_q   <= '0;
      rpt_snap_q   <= 1'b0;
      rpt_ack_q    <= 1'b0;
      cnt_q        <= '0;
      tx_flip_q    <= 1'b0;
      tx_pid_q     <= '0;
      tx_data_q    <= '0;
      tx_len_q     <= '0;
    end else begin
      rx_flip_q    <= rx_flip_d;
      state_q      <= state_d;
      stage_q      <= stage_d;
      dev_addr_q   <= dev_addr_d;
      pend_addr_q  <= pend_addr_d;
      pend_cfg_q   <= pend_cfg_d;
      req_addr_q   <= req_addr_d;
      req_cfg_q    <= req_cfg_d;
      configured_q <= configured_d;
      ep0_tog_q    <= ep0_tog_d;
      ep1_tog_q    <= ep1_tog_d;
      desc_len_q   <= desc_len_d;
      offset_q     <= offset_d;
      wait_ep1_q   <= wait_ep1_d;
      wait_len_q   <= wait_len_d;
      rpt_snap_q   <= rpt_snap_d;
      rpt_ack_q    <= rpt_ack_d;
      cnt_q        <= cnt_d;
      tx_flip_q    <= tx_flip_d;
      tx_pid_q     <= tx_pid_d;
      tx_data_q    <= tx_data_d;
      tx_len_q     <= tx_len_d;
    end
  end

  assign bus.tx_flip_out         = tx_flip_q;
  assign bus.tx_pid              = tx_pid_q;
  assign bus.tx_data             = tx_data_q;
  assign bus.tx_len              = tx_len_q;
  assign bus.report_ack_flip_out = rpt_ack_q;
  assign bus.dev_addr            = dev_addr_q;
  assign bus.configured          = configured_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_ls_hid_device_responder.sv
// +-------------------------------------------------------------------------+
// | tb_usb_ls_hid_device_responder: scoreboard bench for the HID responder  |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_usb_ls_hid_device_responder;
  import usb_ls_pkg::*;

  localparam logic [143:0] c_desc =
    144'h01_00_02_01_01_00_56_78_12_34_08_00_00_00_01_10_01_12;
  localparam int c_timeout = 64;
  localparam logic [63:0] c_get_desc = 64'h0040_0000_0100_0680;
  localparam logic [63:0] c_unknown  = 64'h0001_0000_0000_0A80;
  localparam logic [63:0] c_set_ad5  = 64'h0000_0000_0005_0500;
  localparam logic [63:0] c_set_ad9  = 64'h0000_0000_0009_0500;
  localparam logic [63:0] c_set_cfg1 = 64'h0000_0000_0001_0900;
  localparam logic [63:0] c_report1  = 64'h0000_0000_0004_0002;
  localparam logic [63:0] c_report2  = 64'h0000_0000_0005_0000;

  typedef struct {
    logic [7:0]  pid;
    logic [3:0]  len;
    logic [63:0] data;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  usb_ls_hid_device_responder_if bus();

  usb_ls_hid_device_responder #(
    .DEV_DESC    (c_desc),
    .ACK_TIMEOUT (c_timeout)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic tx_seen  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reply monitor: every tx toggle must match the oldest expected reply
  initial begin
    forever begin
      @(negedge clk);
      if (reset || bus.bus_reset) begin
        tx_seen = bus.tx_flip_out;
      end else if (bus.tx_flip_out !== tx_seen) begin
        tx_seen = bus.tx_flip_out;
        check_val("tx_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check_val({mon_e.tag, "_pid"}, 64'(bus.tx_pid), 64'(mon_e.pid));
          check_val({mon_e.tag, "_len"}, 64'(bus.tx_len), 64'(mon_e.len));
          check_val({mon_e.tag, "_data"}, bus.tx_data, mon_e.data);
          check_val({mon_e.tag, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  function automatic logic [63:0] desc_bytes(input int off, input int n);
    logic [143:0] d;
    logic [63:0]  r;
    d = c_desc;
    r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = d[(off+i)*8 +: 8];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] pid,
                           input logic [3:0] len, input logic [63:0] data);
    exp_t e;
    e.pid  = pid;
    e.len  = len;
    e.data = data;
    e.cyc  = cyc + 1;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic send_pkt(input logic [7:0] pid, input logic [6:0] addr,
                          input logic [3:0] endp, input logic [3:0] len,
                          input logic [63:0] data, input logic crc);
    bus.rx_pid     = pid;
    bus.rx_addr    = addr;
    bus.rx_endp    = endp;
    bus.rx_len     = len;
    bus.rx_data    = data;
    bus.rx_crc_ok  = crc;
    bus.rx_flip_in = ~bus.rx_flip_in;
    tick(3);
  endtask

  task automatic host_ack();
    send_pkt(PID_ACK, 7'd0, 4'd0, 4'd0, 64'd0, 1'b1);
  endtask

  task automatic in_expect(input string tag, input logic [6:0] addr,
                           input logic [3:0] endp, input logic [7:0] pid,
                           input logic [3:0] len, input logic [63:0] data);
    expect_tx(tag, pid, len, data);
    send_pkt(PID_IN, addr, endp, 4'd0, 64'd0, 1'b1);
  endtask

  task automatic setup_req(input string tag, input logic [6:0] addr,
                           input logic [63:0] req);
    send_pkt(PID_SETUP, addr, 4'd0, 4'd0, 64'd0, 1'b1);
    expect_tx(tag, PID_ACK, 4'd0, 64'd0);
    send_pkt(PID_DATA0, addr, 4'd0, 4'd8, req, 1'b1);
  endtask

  task automatic check_drain(input string tag);
    tick(2);
    check_val({tag, "_drain"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    bus.bus_reset      = 1'b0;
    bus.rx_flip_in     = 1'b0;
    bus.rx_pid         = '0;
    bus.rx_addr        = '0;
    bus.rx_endp        = '0;
    bus.rx_len         = '0;
    bus.rx_data        = '0;
    bus.rx_crc_ok      = 1'b0;
    bus.report         = '0;
    bus.report_flip_in = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check_val("rst_dev_addr", 64'(bus.dev_addr), 64'd0);
    check_val("rst_configured", 64'(bus.configured), 64'd0);
    check_val("rst_tx_flip", 64'(bus.tx_flip_out), 64'd0);
    check_val("rst_tx_pid", 64'(bus.tx_pid), 64'd0);
    check_val("rst_tx_len", 64'(bus.tx_len), 64'd0);
    check_val("rst_tx_data", bus.tx_data, 64'd0);
    check_val("rst_rpt_ack", 64'(bus.report_ack_flip_out), 64'd0);

    in_expect("ep1_unconf", 7'd0, 4'd1, PID_STALL, 4'd0, 64'd0);
    in_expect("ep2_stall", 7'd0, 4'd2, PID_STALL, 4'd0, 64'd0);
    send_pkt(PID_SETUP, 7'd0, 4'd0, 4'd0, 64'd0, 1'b0);
    send_pkt(PID_DATA0, 7'd0, 4'd0, 4'd8, c_get_desc, 1'b1);
    in_expect("badcrc_nak", 7'd0, 4'd0, PID_NAK, 4'd0, 64'd0);
    check_drain("errors");

    setup_req("gd_setup", 7'd0, c_get_desc);
    in_expect("gd_in0", 7'd0, 4'd0, PID_DATA1, 4'd8, desc_bytes(0, 8));
    host_ack();
    in_expect("gd_in1", 7'd0, 4'd0, PID_DATA0, 4'd8, desc_bytes(8, 8));
    tick(c_timeout + 8);
    in_expect("gd_retry", 7'd0, 4'd0, PID_DATA0, 4'd8, desc_bytes(8, 8));
    host_ack();
    in_expect("gd_in2", 7'd0, 4'd0, PID_DATA1, 4'd2, desc_bytes(16, 2));
    host_ack();
    in_expect("gd_zlp", 7'd0, 4'd0, PID_DATA0, 4'd0, 64'd0);
    host_ack();
    send_pkt(PID_OUT, 7'd0, 4'd0, 4'd0, 64'd0, 1'b1);
    expect_tx("gd_status", PID_ACK, 4'd0, 64'd0);
    send_pkt(PID_DATA1, 7'd0, 4'd0, 4'd0, 64'd0, 1'b1);
    check_drain("getdesc");

    setup_req("unk_setup", 7'd0, c_unknown);
    in_expect("unk_stall", 7'd0, 4'd0, PID_STALL, 4'd0, 64'd0);

    setup_req("sa_setup", 7'd0, c_set_ad5);
    in_expect("sa_status", 7'd0, 4'd0, PID_DATA1, 4'd0, 64'd0);
    check_val("sa_addr_before_ack", 64'(bus.dev_addr), 64'd0);
    host_ack();
    check_val("sa_addr_after_ack", 64'(bus.dev_addr), 64'd5);
    send_pkt(PID_IN, 7'd0, 4'd0, 4'd0, 64'd0, 1'b1);
    in_expect("sa_new_nak", 7'd5, 4'd0, PID_NAK, 4'd0, 64'd0);
    check_drain("setaddr");

    setup_req("sc_setup", 7'd5, c_set_cfg1);
    in_expect("sc_status", 7'd5, 4'd0, PID_DATA1, 4'd0, 64'd0);
    check_val("sc_cfg_before_ack", 64'(bus.configured), 64'd0);
    host_ack();
    check_val("sc_cfg_after_ack", 64'(bus.configured), 64'd1);

    in_expect("ep1_norpt", 7'd5, 4'd1, PID_NAK, 4'd0, 64'd0);
    bus.report = c_report1;
    bus.report_flip_in = ~bus.report_flip_in;
    tick(1);
    in_expect("ep1_rpt1", 7'd5, 4'd1, PID_DATA0, 4'd8, c_report1);
    bus.report = c_report2;
    bus.report_flip_in = ~bus.report_flip_in;
    tick(1);
    check_val("rpt1_ack_pre", 64'(bus.report_ack_flip_out), 64'd0);
    host_ack();
    check_val("rpt1_ack_post", 64'(bus.report_ack_flip_out), 64'd1);
    in_expect("ep1_rpt2", 7'd5, 4'd1, PID_DATA1, 4'd8, c_report2);
    host_ack();
    check_val("rpt2_ack_post", 64'(bus.report_ack_flip_out), 64'd0);
    in_expect("ep1_drained", 7'd5, 4'd1, PID_NAK, 4'd0, 64'd0);
    check_drain("ep1");

    setup_req("br_setup", 7'd5, c_set_ad9);
    in_expect("br_status", 7'd5, 4'd0, PID_DATA1, 4'd0, 64'd0);
    bus.bus_reset = 1'b1;
    tick(2);
    check_val("br_dev_addr", 64'(bus.dev_addr), 64'd0);
    check_val("br_configured", 64'(bus.configured), 64'd0);
    check_val("br_tx_flip", 64'(bus.tx_flip_out), 64'd0);
    bus.bus_reset = 1'b0;
    tick(1);
    host_ack();
    check_val("br_no_commit", 64'(bus.dev_addr), 64'd0);
    in_expect("br_ep1_stall", 7'd0, 4'd1, PID_STALL, 4'd0, 64'd0);
    in_expect("br_ep0_nak", 7'd0, 4'd0, PID_NAK, 4'd0, 64'd0);
    check_drain("busreset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_ls_hid_device_responder.md
Name: usb_ls_hid_device_responder

Overview:
- Device-side packet-level responder for USB low-speed HID: the function end of the host enumeration/polling sequence.
- Sits above a device-side LS PHY that delivers decoded packets and serialises replies. Exchanges with the PHY use flip (toggle) handshakes.
- Handles EP0 control: GET_DESCRIPTOR(device), SET_ADDRESS, SET_CONFIGURATION. Handles EP1 interrupt IN: 8-byte keyboard report, with DATA0/1 toggling and ACK/NAK/STALL replies.

Parameters:
- DEV_DESC, 144'h (18-byte keyboard device descriptor, byte0=8'h12 in [7:0], byte1=8'h01, byte7=8'h08), device descriptor ROM.
- ACK_TIMEOUT, 1024, clk cycles to wait for host handshake after a DATA reply.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- bus_reset  in  1  USB bus reset (SE0) from PHY, level.
- rx_flip_in  in  1  toggles once per received packet.
- rx_pid  in  8  full PID byte (8'h2D SETUP, 8'h69 IN, 8'hE1 OUT, 8'hC3 DATA0, 8'h4B DATA1, 8'hD2 ACK).
- rx_addr  in  7  token address.
- rx_endp  in  4  token endpoint.
- rx_len  in  4  data payload bytes (0..8).
- rx_data  in  64  payload, byte0 in [7:0].
- rx_crc_ok  in  1  CRC5/CRC16 valid.
- tx_flip_out  out  1  toggles to request one transmit.
- tx_pid  out  8  PID to send.
- tx_data  out  64  payload, byte0 in [7:0].
- tx_len  out  4  payload bytes (0..8; 0 for handshakes and ZLP).
- report  in  64  HID report (byte0 modifiers, byte2..7 keycodes).
- report_flip_in  in  1  toggles when a new report is presented.
- report_ack_flip_out  out  1  toggles when a report has been ACKed by host.
- dev_addr  out  7  current device address.
- configured  out  1  SET_CONFIGURATION with nonzero value done.

Behaviour:
- Reset or bus_reset values: dev_addr=0, configured=0, tx_flip_out=0, tx_pid/tx_data/tx_len=0, report_ack_flip_out=0. All toggles are DATA0, state S_IDLE, pending address cleared. A reset mid-transaction drops the transaction silently.
- Packet acceptance: a packet is accepted on the first cycle rx_flip_in != internal copy; the copy updates that cycle. Packets with rx_crc_ok=0 are ignored. Tokens with rx_addr != dev_addr are ignored.
- Reply latency: on the cycle after acceptance, tx_pid/tx_data/tx_len are stable and tx_flip_out toggles. At most one reply per received packet.
- States:
  - S_IDLE: SETUP to EP0 -> S_SETUP_DATA. OUT to EP0 -> S_OUT_DATA. IN -> reply per endpoint rules.
  - S_SETUP_DATA: expects DATA0 with len 8 -> reply ACK, decode request, -> S_IDLE. Any other packet -> S_IDLE, no reply.
  - S_OUT_DATA: any DATA packet -> ACK (status stage), -> S_IDLE.
  - S_WAIT_ACK: entered after sending a DATA reply. ACK -> commit (below), -> S_IDLE. Timeout after ACK_TIMEOUT cycles or any other packet -> S_IDLE with no commit; a retried IN resends the same data and toggle.
- SETUP decode (bmRequestType byte0, bRequest byte1, wValue bytes2-3, wLength bytes6-7):
  - 0x05 SET_ADDRESS: latch pending address wValue[6:0]; control stage = STATUS_IN.
  - 0x09 SET_CONFIGURATION: configured <= (wValue[7:0] != 0) at ACK of status; control stage = STATUS_IN.
  - 0x06 with wValue[15:8]=1: desc_len = min(wLength,18), offset 0; control stage = DATA_IN.
  - Anything else: control stage = STALL.
  - Every SETUP sets ep0 toggle to DATA1.
- EP0 IN:
  - DATA_IN: send bytes offset..offset+min(8,desc_len-offset)-1 with ep0 toggle. On commit, offset advances and toggle flips. When offset reaches desc_len, further INs get a ZLP.
  - STATUS_IN: send DATA1 ZLP. On commit apply pending address/config, stage -> IDLE.
  - STALL stage: reply 8'h1E.
  - Idle stage: reply NAK (8'h5A).
- EP1 IN:
  - configured=0: STALL.
  - No pending report (report_flip_in == internal copy): NAK.
  - Report pending: send 8-byte report snapshot (captured at the IN) with ep1 toggle. On commit: flip ep1 toggle, update the internal copy, toggle report_ack_flip_out.
  - A new report arriving during S_WAIT_ACK stays pending.
- Other endpoints: STALL.
- Simultaneity: a bus_reset assertion overrides packet processing in the same cycle.

Decomposition:
- Shared package usb_ls_pkg: PID constants, request codes (0x05, 0x06, 0x09), state and control-stage enums.
- One natural sub-module: usb_ls_desc_rom (offset -> 8-byte window of DEV_DESC, zero-padded past the end).

Test Plan:
- SETUP(addr0, EP0) + DATA0 {80 06 00 01 00 00 40 00} -> ACK. Three INs each ACKed -> DATA1 12 01.. len 8, DATA0 len 8, DATA1 len 2. OUT + DATA1 ZLP -> ACK.
- SET_ADDRESS 5: SETUP+DATA0 -> ACK. IN to addr0 -> DATA1 ZLP. Host ACK -> dev_addr=5. Next token to addr0 -> no tx_flip_out change.
- IN not ACKed: IN EP0 during descriptor stage, no ACK for ACK_TIMEOUT cycles, IN again -> identical data and toggle resent; offset unchanged.
- SET_CONFIGURATION 1 then EP1 IN: no report -> NAK. Toggle report_flip_in with report {02 00 04 00..} -> DATA0 that report. ACK -> report_ack_flip_out toggles. Next report -> DATA1.
- Error/stall cases: IN EP1 while configured=0 -> STALL (8'h1E). Bad-CRC SETUP -> no reply. Unknown bRequest 0x0A -> ACK setup, then IN -> STALL.
- bus_reset during S_WAIT_ACK -> next cycle dev_addr=0, configured=0, toggles DATA0, and no commit occurs.
